// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and data
// access. Define MEM_ARB_RR_EN for round-robin; otherwise data beats fetch.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  // fetch requester
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  // data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_owner_d;   // 1 = data requester owns the transaction
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_i_rdata;
  logic          r_i_err;
  logic [DW-1:0] r_d_rdata;
  logic          r_d_err;

  logic          w_grant;
  logic          w_pick_d;
  logic          w_timeout;

  // Winner selection; only meaningful while w_grant is high.
`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  always_comb begin
    w_pick_d = d_req && (!i_req || !r_last_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  always_comb begin
    w_pick_d = d_req;
  end
`endif

  // A grant in the reset cycle would be lost, so it is suppressed.
  assign w_grant   = (r_state == IDLE) && (i_req || d_req) && !reset;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default to holding the current state so no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = MEM;
      MEM:     if (mem_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic; grants are Mealy, everything else follows the state.
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      IDLE: begin
        i_gnt = w_grant && !w_pick_d;
        d_gnt = w_grant && w_pick_d;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = r_we;
        busy    = 1'b1;
      end
      RESP: begin
        i_rvalid = !r_owner_d;
        d_rvalid = r_owner_d;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

  // Transaction registers: captured at grant, completed at ack or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these are small control/data flops, not a memory array, so all of them reset.
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_i_rdata <= '0;
      r_i_err   <= 1'b0;
      r_d_rdata <= '0;
      r_d_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner_d <= w_pick_d;
        r_addr    <= w_pick_d ? d_addr : i_addr;
        r_we      <= w_pick_d && d_we;
        r_wdata   <= w_pick_d ? d_wdata : '0;
        r_cnt     <= '0;
      end
      if (r_state == MEM) begin
        if (mem_ack) begin
          if (r_owner_d) begin
            r_d_rdata <= r_we ? '0 : mem_rdata;
            r_d_err   <= 1'b0;
          end else begin
            r_i_rdata <= mem_rdata;
            r_i_err   <= 1'b0;
          end
        end else if (w_timeout) begin
          if (r_owner_d) begin
            r_d_rdata <= '0;
            r_d_err   <= 1'b1;
          end else begin
            r_i_rdata <= '0;
            r_i_err   <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, tie and reset
// sequences, then random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // wait cycles before ack; >= T means never
    logic [31:0] mrdata;
    int          exp_off;    // rvalid cycle relative to grant
    int          exp_memc;   // cycles with mem_req high
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; d_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single transaction from grant to completion, with a bounded wait.
  task automatic run_txn(input vec_t v);
    int off;
    int memc;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = v.mrdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    check("txn_gnt", v.is_d ? d_gnt : i_gnt, 1);
    check("txn_other_gnt", v.is_d ? i_gnt : d_gnt, 0);
    off = -1;
    memc = 0;
    for (int k = 1; k <= 40 && off < 0; k++) begin
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0;
      i_addr = 32'h0BAD_0001; d_addr = 32'h0BAD_0002; d_wdata = 32'hFFFF_FFFF; d_we = ~d_we;
      mem_ack = (k == v.lat + 1);
      #1;
      if (mem_req) begin
        memc++;
        check("txn_mem_addr", mem_addr, v.addr);
        check("txn_mem_we", mem_we, v.is_d && v.we);
        if (v.is_d && v.we) check("txn_mem_wdata", mem_wdata, v.wdata);
      end
      if (i_rvalid || d_rvalid) begin
        off = k;
        check("txn_rvalid_owner", {i_rvalid, d_rvalid}, v.is_d ? 2'b01 : 2'b10);
        check("txn_rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        check("txn_err", v.is_d ? d_err : i_err, v.exp_err);
      end
    end
    mem_ack = 1'b0;
    check("txn_rvalid_offset", off, v.exp_off);
    check("txn_mem_cycles", memc, v.exp_memc);
    @(negedge clk);
    #1;
    check("txn_idle_after", busy, 0);
  endtask

  initial begin
    logic exp_d;
    // model state for the random phase
    int   t, grant_t, resp_t, m_lat, m;
    logic m_owner_d, m_we, m_err, win_d, gnt, idle, in_mem, last_d;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic ip, dp, io, dout;
    vec_t rv;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        0,  32'hE3A0_1005, 2,  1,  32'hE3A0_1005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 3, 32'h1234_5678, 5,  4,  32'h0,         1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h300, 32'h0,        99, 32'h5555_AAAA, 16, 15, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h304, 32'h0,        14, 32'hCAFE_F00D, 16, 15, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        1,  32'hA5A5_A5A5, 3,  2,  32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h208, 32'h0000_0042, 99, 32'h7777_7777, 16, 15, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h108, 32'h0,        99, 32'h3333_3333, 16, 15, 32'h0,         1'b1};

    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_gnt", {i_gnt, d_gnt}, 0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check("rst_err", {i_err, d_err}, 0);
    check("rst_mem_ctl", {mem_req, mem_we, busy}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Simultaneous requests, four back-to-back ties.
    do_reset();
    for (int it = 0; it < 4; it++) begin
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ack = 1'b0;
      i_addr = 32'h1000 + it; d_addr = 32'h2000 + it;
`ifdef MEM_ARB_RR_EN
      exp_d = (it % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      check("tie_i_gnt", i_gnt, !exp_d);
      check("tie_d_gnt", d_gnt, exp_d);
      @(negedge clk);
      if (exp_d) d_req = 1'b0; else i_req = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("tie_rvalid", {i_rvalid, d_rvalid}, exp_d ? 2'b01 : 2'b10);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset while a load is waiting in MEM.
    do_reset();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    #1;
    check("rstmem_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    check("rstmem_in_mem", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1;
    #1;
    check("rstmem_busy", busy, 0);
    check("rstmem_mem_req", mem_req, 0);
    check("rstmem_rvalid", {i_rvalid, d_rvalid}, 0);
    @(negedge clk);
    #1;
    check("rstmem_spurious_busy", busy, 0);
    check("rstmem_spurious_rvalid", {i_rvalid, d_rvalid}, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("rstmem_no_late_rvalid", {i_rvalid, d_rvalid}, 0);
    rv = '{1'b0, 1'b0, 32'h400, 32'h0, 2, 32'h600D_F00D, 4, 3, 32'h600D_F00D, 1'b0};
    run_txn(rv);

    // Random traffic against a timeline model: each grant fixes when the
    // transaction leaves MEM and when its response appears.
    do_reset();
    grant_t = -1; resp_t = -1; last_d = 1'b0;
    ip = 0; dp = 0; io = 0; dout = 0;
    m_owner_d = 0; m_we = 0; m_err = 0; m_lat = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!ip && !io && $urandom_range(0, 2) == 0) begin
        ip = 1'b1; i_addr = $urandom;
      end else if (!ip) begin
        i_addr = $urandom;
      end
      if (!dp && !dout && $urandom_range(0, 2) == 0) begin
        dp = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
      end else if (!dp) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
      end
      i_req = ip; d_req = dp;
      idle   = (t > resp_t);
      in_mem = (t > grant_t) && (t < resp_t);
      mem_rdata = $urandom;
      if (in_mem) begin
        mem_ack = (t - grant_t - 1 == m_lat);
        if (mem_ack) m_rdata = m_we ? 32'h0 : mem_rdata;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      gnt = idle && (ip || dp);
`ifdef MEM_ARB_RR_EN
      win_d = dp && (!ip || !last_d);
`else
      win_d = dp;
`endif
      #1;
      check("rnd_i_gnt", i_gnt, gnt && !win_d);
      check("rnd_d_gnt", d_gnt, gnt && win_d);
      check("rnd_busy", busy, !idle);
      check("rnd_mem_req", mem_req, in_mem);
      if (in_mem) begin
        check("rnd_mem_addr", mem_addr, m_addr);
        check("rnd_mem_we", mem_we, m_we);
        if (m_we) check("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      check("rnd_rvalid", {i_rvalid, d_rvalid},
            (t == resp_t) ? (m_owner_d ? 2'b01 : 2'b10) : 2'b00);
      if (t == resp_t) begin
        check("rnd_rdata", m_owner_d ? d_rdata : i_rdata, m_rdata);
        check("rnd_err", m_owner_d ? d_err : i_err, m_err);
        if (m_owner_d) dout = 1'b0; else io = 1'b0;
      end
      if (gnt) begin
        case ($urandom_range(0, 9))
          7:       m_lat = T - 1;
          8:       m_lat = T;
          9:       m_lat = 30;
          default: m_lat = $urandom_range(0, 4);
        endcase
        m = (m_lat < T) ? m_lat + 1 : T;
        grant_t   = t;
        resp_t    = t + 1 + m;
        m_owner_d = win_d;
        m_addr    = win_d ? d_addr : i_addr;
        m_we      = win_d && d_we;
        m_wdata   = d_wdata;
        m_err     = (m_lat >= T);
        m_rdata   = 32'h0;
        last_d    = win_d;
        if (win_d) begin dp = 1'b0; dout = 1'b1; end
        else       begin ip = 1'b0; io = 1'b1; end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the multicycle core between the instruction-fetch requester (Fetch state) and the data requester (MemRead/MemWrite states). Arbitrates, issues one memory transaction at a time, waits for a variable-latency memory acknowledge with timeout, and returns a one-cycle response with read data or error to the granted requester. Sits between the core control FSM/datapath and the memory model or bus.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, max cycles mem_req is held without mem_ack before error completion (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted (one cycle)
- i_rvalid  out  1  fetch completion (one cycle)
- i_rdata  out  DW  fetch read data, valid with i_rvalid
- i_err  out  1  fetch timed out, valid with i_rvalid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted (one cycle)
- d_rvalid  out  1  data completion (one cycle, loads and stores)
- d_rdata  out  DW  load data, valid with d_rvalid; 0 for stores
- d_err  out  1  data timed out, valid with d_rvalid
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion; rdata valid same cycle
- mem_rdata  in  DW  memory read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MEM, RESP. One outstanding transaction; no pipelining.
- IDLE: if i_req or d_req, choose winner combinationally, assert its gnt this cycle (Mealy), latch owner, addr, we (fetch: we=0), wdata; next MEM. Otherwise stay.
- Fixed priority (default): d_req beats i_req.
- MEM: mem_req=1, mem_we/mem_addr/mem_wdata driven from latched regs. On mem_ack: latch mem_rdata (stores latch 0), err=0, next RESP. Without ack: increment wait counter; if counter == TIMEOUT-1, latch rdata=0, err=1, next RESP.
- Wait counter cleared on entry to MEM; width clog2(TIMEOUT+1).
- RESP: owner's rvalid=1 for one cycle with latched rdata/err; other requester's rvalid=0; next IDLE. No grant issued in RESP.
- gnt asserted only in IDLE; requests arriving in MEM/RESP wait for IDLE. Requester may drop req after gnt; must not re-request before its rvalid.
- mem_ack outside MEM ignored. Address/data inputs sampled only in the grant cycle.
- Reset (any state): next cycle IDLE, all outputs 0, counter 0, in-flight transaction discarded with no rvalid; RR pointer reset.
- Outputs rdata/err hold last value outside RESP; only rvalid qualifies them.

## Timing
- Reset values: all gnt, rvalid, err, mem_req, mem_we, busy = 0; rdata, mem_addr, mem_wdata = 0.
- Zero-wait memory (ack in first MEM cycle): gnt at cycle N, mem_req at N+1, rvalid at N+2; next grant earliest N+3.
- N wait cycles: rvalid at grant+2+N.
- Timeout: mem_req high exactly TIMEOUT cycles, then rvalid+err next cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous i_req and d_req grant the requester not granted last; single request always granted. Last-granted pointer resets to fetch, so first tie goes to data.
- Undefined: fixed priority, data over fetch; no pointer logic.

## Test plan
- Single fetch, i_addr=0x100, mem_ack in first MEM cycle, mem_rdata=0xE3A01005 -> i_gnt cycle N, mem_req/mem_addr=0x100 at N+1, i_rvalid with i_rdata=0xE3A01005, i_err=0 at N+2.
- Store d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, ack after 3 waits -> mem_we=1, mem_wdata=0xDEADBEEF for 4 cycles, d_rvalid with d_rdata=0 at grant+5.
- i_req and d_req same cycle, repeated 4 times -> fixed: d granted every time; with MEM_ARB_RR_EN: grants d,i,d,i.
- Load, mem_ack never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then d_rvalid=1, d_err=1, d_rdata=0, back to IDLE.
- reset asserted during MEM -> next cycle busy=0, mem_req=0, no rvalid; spurious mem_ack afterwards ignored; new i_req granted normally.
